// File: rtl/exe_muldiv_ctrl.sv
// ============================================================================
// Module      : exe_muldiv_ctrl
// Description : Iterative MULT/MULTU/DIV/DIVU sequencer for the EXE stage.
//               Owns HI/LO and stalls the pipeline while an operation is in
//               flight. Optional macro: MULDIV_EARLY_TERM_EN (multiply early
//               termination once the remaining multiplier bits are zero).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module exe_muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             estart,
    input  logic [1:0]       eop,
    input  logic [WIDTH-1:0] ea,
    input  logic [WIDTH-1:0] eb,
    input  logic             emfhi,
    input  logic             emflo,
    output logic             stall,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] ehilo
);

    localparam int c_CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BUSY   = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic                   r_busy;
    logic [WIDTH-1:0]       r_hi;
    logic [WIDTH-1:0]       r_lo;
    logic [c_CNT_W-1:0]     r_cnt;
    logic                   r_is_div;
    logic                   r_neg_q;
    logic                   r_neg_r;
    logic                   r_dbz;
    logic [2*WIDTH-1:0]     r_acc;
    logic [2*WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]       r_b;

    logic                   w_a_neg;
    logic                   w_b_neg;
    logic [WIDTH-1:0]       w_a_abs;
    logic [WIDTH-1:0]       w_b_abs;
    logic [2*WIDTH-1:0]     w_mul_acc;
    logic [WIDTH:0]         w_div_hi;
    logic [WIDTH:0]         w_trial;
    logic [2*WIDTH-1:0]     w_div_acc;
    logic [2*WIDTH-1:0]     w_prod_fix;
    logic [WIDTH-1:0]       w_quo;
    logic [WIDTH-1:0]       w_rem;

    // eop[0]==0 selects the signed flavour of both MULT and DIV
    assign w_a_neg = ~eop[0] & ea[WIDTH-1];
    assign w_b_neg = ~eop[0] & eb[WIDTH-1];
    assign w_a_abs = w_a_neg ? -ea : ea;
    assign w_b_abs = w_b_neg ? -eb : eb;

    assign w_mul_acc = r_b[0] ? (r_acc + r_mcand) : r_acc;

    // r_acc holds {remainder, dividend/quotient}; trial-subtract on the shifted remainder
    assign w_div_hi  = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_trial   = w_div_hi - {1'b0, r_b};
    assign w_div_acc = w_trial[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                      : {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

    assign w_prod_fix = r_neg_q ? -r_acc : r_acc;
    assign w_quo      = r_dbz ? {WIDTH{1'b1}}
                              : (r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0]);
    assign w_rem      = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (estart) begin
                    w_next = S_BUSY;
                end
            end
            S_BUSY: begin
                if (r_cnt == c_CNT_W'(1)) begin
                    w_next = S_FINISH;
                end
`ifdef MULDIV_EARLY_TERM_EN
                else if (!r_is_div && (r_b[WIDTH-1:1] == '0)) begin
                    w_next = S_FINISH;
                end
`endif
            end
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dbz    <= 1'b0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_b      <= '0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (estart) begin
                        r_is_div <= eop[1];
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        r_dbz    <= (eb == '0);
                        r_cnt    <= c_CNT_W'(WIDTH);
                        r_b      <= w_b_abs;
                        r_mcand  <= {{WIDTH{1'b0}}, w_a_abs};
                        r_acc    <= eop[1] ? {{WIDTH{1'b0}}, w_a_abs} : '0;
                    end
                end
                S_BUSY: begin
                    r_cnt <= r_cnt - c_CNT_W'(1);
                    if (r_is_div) begin
                        r_acc <= w_div_acc;
                    end else begin
                        r_acc   <= w_mul_acc;
                        r_mcand <= r_mcand << 1;
                        r_b     <= r_b >> 1;
                    end
                end
                S_FINISH: begin
                    if (r_is_div) begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                    end else begin
                        r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy  = r_busy;
    assign hi    = r_hi;
    assign lo    = r_lo;
    assign stall = (r_state != S_IDLE) & (estart | emfhi | emflo);
    assign ehilo = emfhi ? r_hi : r_lo;

endmodule

`default_nettype wire
